// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin selector feeding a single registered output slot,
// with saturating per-source transfer counters.
module mux_sel_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             sel,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  typedef enum logic {StEmpty, StFull} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   y_data_q;
  logic               sel_q;
  logic               last_grant_q;  // 0 = A, 1 = B
  logic [CNT_W-1:0]   a_cnt_q, b_cnt_q;

  logic can_load;
  logic grant_a, grant_b;
  logic a_xfer, b_xfer;

  // Under contention the source that did not win last time is granted.
  always_comb begin
    can_load = (state_q == StEmpty) | y_ready;
    grant_a  = a_valid & (~b_valid | last_grant_q);
    grant_b  = b_valid & (~a_valid | ~last_grant_q);
    a_ready  = rst_n & can_load & grant_a;
    b_ready  = rst_n & can_load & grant_b;
    a_xfer   = a_valid & a_ready;
    b_xfer   = b_valid & b_ready;
  end

  always_comb begin
    state_d = state_q;
    if (a_xfer || b_xfer) begin
      state_d = StFull;
    end else if (y_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      y_data_q     <= '0;
      sel_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (a_xfer) begin
        y_data_q     <= a_data;
        sel_q        <= 1'b0;
        last_grant_q <= 1'b0;
      end else if (b_xfer) begin
        y_data_q     <= b_data;
        sel_q        <= 1'b1;
        last_grant_q <= 1'b1;
      end
    end
  end

  // Clear takes priority over a same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else if (cnt_clr) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      if (a_xfer && (a_cnt_q != CntMax)) a_cnt_q <= a_cnt_q + 1'b1;
      if (b_xfer && (b_cnt_q != CntMax)) b_cnt_q <= b_cnt_q + 1'b1;
    end
  end

  assign y_valid = (state_q == StFull);
  assign y_data  = y_data_q;
  assign sel     = sel_q;
  assign a_cnt   = a_cnt_q;
  assign b_cnt   = b_cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Randomized and directed bench for mux_sel_arbiter against a transaction-level model.
module tb_mux_sel_arbiter;

  localparam int W = 8;
  localparam int C = 4;
  localparam int CMAX = (1 << C) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic         a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0, cnt_clr = 1'b0;
  logic         a_ready, b_ready, y_valid, sel;
  logic [W-1:0] y_data;
  logic [C-1:0] a_cnt, b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: slot contents, last winner (1 = B) and counters.
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_sel;
  bit       m_last_b;
  int       m_a_cnt, m_b_cnt;

  mux_sel_arbiter #(.WIDTH(W), .CNT_W(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .y_data  (y_data),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .sel     (sel),
    .cnt_clr (cnt_clr),
    .a_cnt   (a_cnt),
    .b_cnt   (b_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_sel = 0; m_last_b = 1; m_a_cnt = 0; m_b_cnt = 0;
  endtask

  task automatic check_outputs(input string where);
    check_eq({where, ".y_valid"}, y_valid, m_valid);
    check_eq({where, ".y_data"}, y_data, m_data);
    check_eq({where, ".sel"}, sel, m_sel);
    check_eq({where, ".a_cnt"}, a_cnt, m_a_cnt);
    check_eq({where, ".b_cnt"}, b_cnt, m_b_cnt);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit av, input bit [7:0] ad, input bit bv, input bit [7:0] bd,
                       input bit yr, input bit clr);
    int  gnt;
    bit  room, ar, br;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr; cnt_clr = clr;
    #1;
    if (av && bv)  gnt = m_last_b ? 1 : 2;
    else if (av)   gnt = 1;
    else if (bv)   gnt = 2;
    else           gnt = 0;
    room = !m_valid || yr;
    ar = room && gnt == 1;
    br = room && gnt == 2;
    check_eq("a_ready", a_ready, ar);
    check_eq("b_ready", b_ready, br);
    @(posedge clk);
    if (ar) begin
      m_valid = 1; m_data = ad; m_sel = 0; m_last_b = 0;
    end else if (br) begin
      m_valid = 1; m_data = bd; m_sel = 1; m_last_b = 1;
    end else if (yr) begin
      m_valid = 0;
    end
    if (clr) begin
      m_a_cnt = 0; m_b_cnt = 0;
    end else begin
      if (ar && m_a_cnt < CMAX) m_a_cnt++;
      if (br && m_b_cnt < CMAX) m_b_cnt++;
    end
    @(negedge clk);
    check_outputs("post");
  endtask

  initial begin
    model_reset();
    a_valid = 1; b_valid = 1; y_ready = 1;
    #1 rst_n = 1'b0;
    #2;
    check_outputs("reset");
    check_eq("reset.a_ready", a_ready, 1'b0);
    check_eq("reset.b_ready", b_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Contention alternates starting with A.
    repeat (4) cycle(1, 8'h11, 1, 8'h22, 1, 0);
    check_eq("alt.a_cnt", a_cnt, 2);
    check_eq("alt.b_cnt", b_cnt, 2);

    // Stall with B held in the slot.
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 1, 8'h5A, 0, 0);
    check_eq("stall.y_data", y_data, 8'h5A);
    repeat (5) cycle(0, 0, 1, 8'hC3, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    check_eq("drain.y_valid", y_valid, 1'b0);

    // Replace-while-draining without a bubble.
    cycle(1, 8'h44, 0, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 1, 0);
    check_eq("nobubble.y_data", y_data, 8'h33);

    // Saturation, then clear wins over a concurrent transfer.
    cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) cycle(1, 8'(i), 0, 0, 1, 0);
    check_eq("sat.a_cnt", a_cnt, CMAX);
    cycle(1, 8'hEE, 0, 0, 1, 1);
    check_eq("clr.a_cnt", a_cnt, 0);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges while full.
    cycle(0, 0, 1, 8'h77, 0, 0);
    cycle(1, 8'h78, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset");
    check_eq("areset.a_ready", a_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 8'hA1, 1, 8'hB2, 1, 0);
    check_eq("postrst.sel", sel, 1'b0);
    check_eq("postrst.y_data", y_data, 8'hA1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data path width in bits.
REQ-002 Parameter: CNT_W, default 16, width of each transfer counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: a_data  input  WIDTH  source A payload.
REQ-007 Port: a_valid  input  1  source A payload valid.
REQ-008 Port: a_ready  output  1  block accepts A this cycle.
REQ-009 Port: b_data  input  WIDTH  source B payload.
REQ-010 Port: b_valid  input  1  source B payload valid.
REQ-011 Port: b_ready  output  1  block accepts B this cycle.
REQ-012 Port: y_data  output  WIDTH  registered selected payload.
REQ-013 Port: y_valid  output  1  y_data holds an unconsumed word.
REQ-014 Port: y_ready  input  1  downstream accepts y_data.
REQ-015 Port: sel  output  1  origin of the word in y_data (0 = A, 1 = B), registered.
REQ-016 Port: cnt_clr  input  1  synchronous clear of both counters.
REQ-017 Port: a_cnt  output  CNT_W  accepted A transfers, saturating.
REQ-018 Port: b_cnt  output  CNT_W  accepted B transfers, saturating.

Function
REQ-019 Output stage SHALL be one register slot with states EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-020 can_load SHALL equal (~y_valid | y_ready), combinational.
REQ-021 Grant: only A valid -> A; only B valid -> B; both valid -> the source not equal to last_grant; neither -> no grant.
REQ-022 a_ready SHALL equal can_load & grant==A, and b_ready SHALL equal can_load & grant==B; they SHALL never both be 1.
REQ-023 A transfer occurs on a cycle with x_valid & x_ready; on that edge y_data<=x_data, sel<=source, y_valid<=1, last_grant<=source.
REQ-024 When y_valid & y_ready and no input transfer occurs, y_valid SHALL go to 0; y_data and sel hold.
REQ-025 When y_valid & y_ready and an input transfer occurs in the same cycle, the new word SHALL load with y_valid remaining 1 (full throughput, one word per cycle).
REQ-026 Latency from input transfer to y_valid SHALL be exactly 1 cycle.
REQ-027 When FULL and y_ready=0, y_data, sel and y_valid SHALL hold and a_ready=b_ready=0.
REQ-028 Grant decision SHALL be a pure function of current valids and last_grant; last_grant changes only on a transfer.
REQ-029 With both sources continuously valid and y_ready=1, grants SHALL alternate every cycle (no starvation).
REQ-030 a_cnt/b_cnt SHALL increment by 1 on each transfer of their source and saturate at 2^CNT_W-1 (no wrap).
REQ-031 cnt_clr=1 SHALL zero both counters on the next edge; a transfer in the same cycle SHALL NOT be counted.
REQ-032 Source payload SHALL be ignored whenever its ready is 0.

Reset
REQ-033 On rst_n=0, immediately and without clock: y_valid=0, y_data=0, sel=0, last_grant=1 (so A wins first contention), a_cnt=0, b_cnt=0.
REQ-034 While rst_n=0, a_ready=b_ready=0.
REQ-035 Reset asserted mid-transfer SHALL discard the held word; first transfer after deassertion follows REQ-021 from reset state.

Verification
REQ-036 After reset, a_valid=b_valid=1, a_data=0x11, b_data=0x22, y_ready=1 for 4 cycles -> y_data sequence 0x11,0x22,0x11,0x22, sel 0,1,0,1, a_cnt=2, b_cnt=2.
REQ-037 Only b_valid=1 with 0x5A, y_ready=0 -> one cycle later y_valid=1, y_data=0x5A, sel=1; b_ready=0 thereafter; y_data stable 5 stall cycles; y_ready=1 -> y_valid=0 next edge.
REQ-038 y_valid=1, y_ready=1, a_valid=1 a_data=0x33 same cycle -> a_ready=1, next cycle y_valid=1, y_data=0x33 (no bubble).
REQ-039 CNT_W=4, A streams 20 words -> a_cnt reaches 15 and holds; cnt_clr pulse with concurrent A transfer -> a_cnt=0.
REQ-040 rst_n dropped asynchronously between edges while FULL -> y_valid, counters to 0 before next edge; after release both valid -> A granted first.
